// File: rtl/nip_pkg.sv
// nip_pkg: shared constants and FSM encodings for the network input path.
package nip_pkg;
    localparam int BUFID_WIDTH = 9;
    localparam int NUM_PORTS = 2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LOAD = 2'd2
    } dispatch_state_e;
endpackage

// File: rtl/bufid_slot.sv
// bufid_slot: one prefetched bufid offered to a port, held until the port acks it.
module bufid_slot
    import nip_pkg::*;
#(
    parameter int W = BUFID_WIDTH
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] bufid
);
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid <= 1'b0;
            bufid <= '0;
        end else if (load) begin
            valid <= 1'b1;
            bufid <= din;
        end else if (ack && valid) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pkt_bufid_dispatch.sv
// pkt_bufid_dispatch: prefetches free bufids from the shared pool into one slot per
// input port, refilling round-robin while the pool stays above the reserve threshold.
module pkt_bufid_dispatch #(
    parameter int BUFID_WIDTH = nip_pkg::BUFID_WIDTH
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    output logic                   o_free_bufid_rd,
    input  logic [BUFID_WIDTH-1:0] iv_free_bufid,
    input  logic                   i_free_bufid_fifo_empty,
    input  logic [8:0]             iv_free_bufid_fifo_rdusedw,
    input  logic [8:0]             iv_reserve_threshold,
    output logic                   o_pkt_bufid_wr_p0,
    output logic                   o_pkt_bufid_wr_p1,
    output logic [BUFID_WIDTH-1:0] ov_pkt_bufid_p0,
    output logic [BUFID_WIDTH-1:0] ov_pkt_bufid_p1,
    input  logic                   i_pkt_bufid_ack_p0,
    input  logic                   i_pkt_bufid_ack_p1,
    output logic                   o_bufid_starve_pulse,
    output logic [1:0]             ov_dispatch_state
);
    import nip_pkg::*;

    dispatch_state_e state, state_nxt;
    logic rr, rr_nxt, tgt, tgt_nxt, starve;
    logic any_empty, can_refill, pick;
    logic [NUM_PORTS-1:0] slot_valid, slot_load, slot_ack;
    logic [BUFID_WIDTH-1:0] slot_bufid [NUM_PORTS];

    assign slot_ack = {i_pkt_bufid_ack_p1, i_pkt_bufid_ack_p0};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        bufid_slot #(.W(BUFID_WIDTH)) u_slot (
            .clk_sys (clk_sys),
            .reset   (reset),
            .load    (slot_load[i]),
            .din     (iv_free_bufid),
            .ack     (slot_ack[i]),
            .valid   (slot_valid[i]),
            .bufid   (slot_bufid[i])
        );
    end

    assign any_empty  = ~&slot_valid;
    assign can_refill = !i_free_bufid_fifo_empty && (iv_free_bufid_fifo_rdusedw > iv_reserve_threshold);
    assign pick       = slot_valid[rr] ? ~rr : rr;

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        rr_nxt    = rr;
        slot_load = '0;
        case (state)
            IDLE: if (any_empty && can_refill) begin
                state_nxt = RD;
                tgt_nxt   = pick;
            end
            RD:   state_nxt = LOAD;
            LOAD: begin
                state_nxt      = IDLE;
                slot_load[tgt] = 1'b1;
                rr_nxt         = ~tgt;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= IDLE;
            tgt    <= 1'b0;
            rr     <= 1'b0;
            starve <= 1'b0;
        end else begin
            state  <= state_nxt;
            tgt    <= tgt_nxt;
            rr     <= rr_nxt;
            starve <= (state == IDLE) && any_empty && !can_refill;
        end
    end

    // Read data arrives during LOAD, one cycle after the strobe decoded from RD.
    assign o_free_bufid_rd      = (state == RD);
    assign ov_dispatch_state    = state;
    assign o_bufid_starve_pulse = starve;
    assign o_pkt_bufid_wr_p0    = slot_valid[0];
    assign o_pkt_bufid_wr_p1    = slot_valid[1];
    assign ov_pkt_bufid_p0      = slot_bufid[0];
    assign ov_pkt_bufid_p1      = slot_bufid[1];
endmodule
